// File: rtl/wait_timer_pkg.sv
// wait_timer_pkg: shared FSM encoding and default sizing for the wait timer arbiter
package wait_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int TICK_CYCLES_DEF = 100_000_000;
  localparam int DUR_W_DEF = 8;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick on its last count
// clk/reset: clock and async active-high reset
// clr: synchronous clear to zero, en: count enable, tick: one-cycle pulse at TICK_CYCLES-1
module tick_prescaler #(
  parameter int TICK_CYCLES = wait_timer_pkg::TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_CYCLES);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(TICK_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/wait_timer_arbiter.sv
// wait_timer_arbiter: round-robin sharing of one programmable tick-based wait timer
// clk/reset: clock and async active-high reset
// req: level requests, dur: packed per-requester tick counts sampled at grant, cancel: abort current wait
// grant: one-hot owner of the timer, done: expiry pulse, busy: wait active, remaining: ticks left
module wait_timer_arbiter
  import wait_timer_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  input  logic                     cancel,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [DUR_W-1:0]         remaining
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  state_t state, state_n;
  logic [IW-1:0] rr, rr_n, w, w_n, pick, w_next;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic busy_n, tick, abort;
  logic [DUR_W-1:0] rem_n, dur_sel, rem_load;

  tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .en    (state == RUN),
    .tick  (tick)
  );

  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin
    pick = rr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NUM_REQ]) pick = IW'((int'(rr) + i) % NUM_REQ);
  end

  assign dur_sel = dur[int'(pick)*DUR_W +: DUR_W];
  assign rem_load = dur_sel == '0 ? DUR_W'(1) : dur_sel;
  assign w_next = w == LAST ? '0 : w + IW'(1);
  assign abort = cancel || !req[w];

  always_comb begin
    state_n = state;
    rr_n = rr;
    w_n = w;
    grant_n = grant;
    done_n = '0;
    busy_n = busy;
    rem_n = remaining;
    case (state)
      IDLE:
        if (|req) begin
          state_n = RUN;
          w_n = pick;
          grant_n = NUM_REQ'(1) << pick;
          busy_n = 1'b1;
          rem_n = rem_load;
        end
      RUN:
        if (abort || (tick && remaining == DUR_W'(1))) begin
          state_n = abort ? IDLE : DONE;
          done_n = abort ? '0 : grant;
          rr_n = w_next;
          grant_n = '0;
          busy_n = 1'b0;
          rem_n = '0;
        end else if (tick) rem_n = remaining - DUR_W'(1);
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      w <= '0;
      grant <= '0;
      done <= '0;
      busy <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      w <= w_n;
      grant <= grant_n;
      done <= done_n;
      busy <= busy_n;
      remaining <= rem_n;
    end
endmodule

// File: tb/tb_wait_timer_arbiter.sv
// tb_wait_timer_arbiter: scoreboard bench with a deadline-based reference model
module tb_wait_timer_arbiter;
  localparam int N = 4, T = 4, W = 8;
  localparam int EV_GRANT = 16, EV_DONE = 32, EV_ABORT = 48;
  logic clk = 1'b0, reset = 1'b1, cancel = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dur = '0;
  logic [N-1:0] grant, done;
  logic busy;
  logic [W-1:0] remaining;
  int tests = 0, fails = 0;
  int exp_q[$];
  int cyc = 0, ms = 0, mw = 0, mrr = 0, mstart = 0, mlen = 0, exp_out = 0;
  logic [N-1:0] prev_g = '0;

  always #5 clk = ~clk;

  wait_timer_arbiter #(.NUM_REQ(N), .TICK_CYCLES(T), .DUR_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dur       (dur),
    .cancel    (cancel),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int idx(input logic [N-1:0] v);
    int r = 99;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int dur_of(input int i);
    return int'(dur[i*W +: W]);
  endfunction

  // Reference: a wait is a deadline at grant_edge + max(dur,1)*T edges;
  // ticks left is the ceiling of the distance to the deadline in ticks.
  always @(posedge clk) begin
    int w;
    cyc++;
    w = 0;
    if (reset) begin
      ms = 0;
      mrr = 0;
      exp_q.delete();
    end else
      case (ms)
        0:
          if (req != 0) begin
            for (int k = N - 1; k >= 0; k--) if (req[(mrr + k) % N]) w = (mrr + k) % N;
            mw = w;
            mstart = cyc;
            mlen = (dur_of(w) == 0 ? 1 : dur_of(w)) * T;
            ms = 1;
            exp_q.push_back(EV_GRANT + w);
          end
        1:
          if (cancel || !req[mw]) begin
            ms = 0;
            mrr = (mw + 1) % N;
            exp_q.push_back(EV_ABORT + mw);
          end else if (cyc == mstart + mlen) begin
            ms = 2;
            mrr = (mw + 1) % N;
            exp_q.push_back(EV_DONE + mw);
          end
        default: ms = 0;
      endcase
    exp_out = ms == 1 ? ((1 << mw) << 9) | (1 << 8) | ((mstart + mlen - cyc + T - 1) / T) : 0;
  end

  always @(posedge clk) begin
    int obs, e;
    #1;
    if (reset) prev_g = '0;
    else begin
      obs = 0;
      if (done != 0) obs = EV_DONE + idx(done);
      else if (prev_g == 0 && grant != 0) obs = EV_GRANT + idx(grant);
      else if (prev_g != 0 && grant == 0) obs = EV_ABORT + idx(prev_g);
      if (obs != 0 || exp_q.size() != 0) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 0;
        check("event", obs, e);
      end
      check("grant_busy_rem", int'({grant, busy, remaining}), exp_out);
      prev_g = grant;
    end
  end

  task automatic idle(input int n);
    req = '0;
    cancel = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_values", int'({grant, done, busy, remaining}), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    // Reset in the middle of a dur=5 wait.
    dur[0*W +: W] = 8'd5;
    req = 4'b0001;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1 check("reset_async", int'({grant, done, busy, remaining}), 0);
    @(negedge clk) reset = 1'b0;
    req = 4'b0110;
    @(negedge clk) check("rr_after_reset", int'(grant), 4'b0010);
    idle(4);
    // Single requester 2, dur=3.
    dur[2*W +: W] = 8'd3;
    req = 4'b0100;
    @(negedge clk) check("grant_req2", int'(grant), 4'b0100);
    repeat (14) @(negedge clk);
    idle(3);
    // All requesting, dur=1 each: round-robin rotation with 2-cycle gaps.
    dur = {4{8'd1}};
    req = 4'b1111;
    repeat (32) @(negedge clk);
    idle(3);
    // dur=0 treated as one tick.
    dur[0*W +: W] = 8'd0;
    req = 4'b0001;
    repeat (8) @(negedge clk);
    idle(3);
    // Cancel 5 cycles into a dur=2 wait.
    dur = {4{8'd2}};
    req = 4'b0011;
    repeat (6) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk) cancel = 1'b0;
    check("cancel_grant_low", int'(grant), 0);
    repeat (12) @(negedge clk);
    idle(3);
    // req[1] dropped in the cycle of its expiry tick.
    dur[1*W +: W] = 8'd1;
    req = 4'b0010;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    @(negedge clk) check("drop_no_done", int'({grant, done}), 0);
    idle(3);
    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(39) == 0) req[i] = 1'b0;
        end else if ($urandom_range(5) == 0) req[i] = 1'b1;
        if ($urandom_range(9) == 0) dur[i*W +: W] = 8'($urandom_range(3));
      end
      cancel = $urandom_range(49) == 0;
      @(negedge clk);
    end
    idle(4);
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
